// File: rtl/mult.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per clock,
// full-width product presented with a level enable / done handshake.
module mult #(
    parameter int in_width  = 4,
    parameter int out_width = 2 * in_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [in_width-1:0]  data_multiplicand,
    input  logic [in_width-1:0]  data_multiplier,
    input  logic                 ctrl_enable,
    output logic [out_width-1:0] data_result,
    output logic                 ctrl_done
);

    localparam int CW = $clog2(in_width + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [out_width-1:0] acc_q, acc_d;
    logic [out_width-1:0] mcand_q, mcand_d;
    logic [in_width-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [out_width-1:0] result_q, result_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (ctrl_enable) begin
                    mcand_d  = out_width'(data_multiplicand);
                    mplier_d = data_multiplier;
                    acc_d    = '0;
                    cnt_d    = CW'(in_width);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Iterate while bits remain; the cycle after the last one publishes.
                if (cnt_q != '0) begin
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!ctrl_enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign data_result = result_q;
    assign ctrl_done   = done_q;

endmodule

// File: tb/tb_mult.sv
// Bench for mult: behavioural model checked every cycle, directed handshake
// scenarios with literal expectations, then randomized traffic with resets.
module tb_mult;

    localparam int W  = 4;
    localparam int OW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a   = '0;
    logic [W-1:0]  b   = '0;
    logic          en  = 1'b0;
    logic [OW-1:0] result;
    logic          done;

    int vectors    = 0;
    int miscompares = 0;

    mult #(.in_width(W), .out_width(OW)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_multiplicand(a),
        .data_multiplier  (b),
        .ctrl_enable      (en),
        .data_result      (result),
        .ctrl_done        (done)
    );

    always #5 clk = ~clk;

    // Model: a start snapshots the operands; the product a*b appears
    // W+1 edges later and stays until the next completion or reset.
    int            m_phase = 0;   // 0 idle, 1 computing, 2 presenting
    int            m_left  = 0;
    int            m_a     = 0;
    int            m_b     = 0;
    logic [OW-1:0] m_res   = '0;
    logic          m_done  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_res   <= '0;
            m_done  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (en) begin
                    m_a     <= int'(a);
                    m_b     <= int'(b);
                    m_left  <= W + 1;
                    m_phase <= 1;
                end
                1: if (m_left == 1) begin
                    m_res   <= OW'(m_a * m_b);
                    m_done  <= 1'b1;
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (!en) begin
                    m_done  <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Advance one clock and compare DUT against the model away from the edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (result !== m_res || done !== m_done) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t result=%0d done=%b expected result=%0d done=%b",
                     $time, result, done, m_res, m_done);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Start with enable held, wait for done, check latency and product, then release.
    task automatic run_op(input int x, input int y, input int exp);
        int n;
        a  = W'(x);
        b  = W'(y);
        en = 1'b1;
        n  = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
        check("latency", n, W + 2);
        check("result_at_done", int'(result), exp);
        en = 1'b0;
        tick();
        check("done_drop", int'(done), 0);
        check("result_in_idle", int'(result), exp);
    endtask

    initial begin
        int hi_cnt;
        rst = 1'b1;
        repeat (10) tick();
        check("reset_result", int'(result), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        run_op(7, 5, 35);
        run_op(15, 15, 225);
        run_op(0, 9, 0);
        run_op(1, 15, 15);
        run_op(8, 2, 16);

        // Operand changes while computing must be ignored.
        a = 4'd7; b = 4'd5; en = 1'b1;
        tick();
        tick();
        a = 4'd3; b = 4'd3; en = 1'b0;
        repeat (W + 1) tick();
        check("busy_input_change", int'(result), 35);
        tick();

        // Reset on the third computing cycle discards the operation.
        a = 4'd6; b = 4'd6; en = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midop_reset_result", int'(result), 0);
        check("midop_reset_done", int'(done), 0);
        rst = 1'b0;
        hi_cnt = 0;
        repeat (4) begin
            tick();
            if (done) hi_cnt++;
        end
        check("no_done_after_reset", hi_cnt, 0);
        en = 1'b0;
        repeat (8) tick();
        run_op(6, 6, 36);

        // Single-cycle enable pulse: done lasts exactly one cycle.
        a = 4'd4; b = 4'd3; en = 1'b1;
        tick();
        en = 1'b0;
        hi_cnt = 0;
        repeat (10) begin
            tick();
            if (done) hi_cnt++;
        end
        check("pulse_done_cycles", hi_cnt, 1);
        check("pulse_result", int'(result), 12);

        // Enable held across completion: stays presenting, no recompute.
        a = 4'd3; b = 4'd7; en = 1'b1;
        repeat (W + 2) tick();
        a = 4'd15; b = 4'd15;
        repeat (10) tick();
        check("hold_done", int'(done), 1);
        check("hold_result", int'(result), 21);
        en = 1'b0;
        tick();
        run_op(2, 9, 18);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
